// File: rtl/addend_align_pipe.sv
// Two-stage elastic addend alignment for the FMA datapath: decodes the
// product/addend exponent gap, then right-shifts C into the adder field.
module addend_align_pipe #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int BIAS      = 127
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_WIDTH-1:0]          a_exp,
  input  logic [EXP_WIDTH-1:0]          b_exp,
  input  logic [EXP_WIDTH-1:0]          c_exp,
  input  logic [SIG_WIDTH:0]            c_sig,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3*(SIG_WIDTH+1)+7:0]    aligned,
  output logic [5:0]                    shamt,
  output logic                          cExpIsSmall,
  output logic                          sticky,
  output logic [EXP_WIDTH-1:0]          res_exp
);

  localparam int SW     = SIG_WIDTH + 1;
  localparam int FW     = 3 * SW + 8;
  localparam int MAX_SH = 2 * SW + 8;
  localparam int PW     = EXP_WIDTH + 3;

  localparam logic signed [PW-1:0] BIAS_S   = PW'(BIAS);
  localparam logic signed [PW-1:0] ZERO_S   = '0;
  localparam logic signed [PW-1:0] MAX_SH_S = PW'(MAX_SH);
  localparam logic signed [PW-1:0] RES_TH_S = PW'(SIG_WIDTH + 4);

  logic signed [PW-1:0]   pe_s;
  logic signed [PW-1:0]   raw_s;
  logic [5:0]             dec_shamt_s;
  logic                   dec_small_s;
  logic [EXP_WIDTH-1:0]   dec_res_exp_s;

  logic                   s1_valid_r;
  logic [5:0]             s1_shamt_r;
  logic                   s1_small_r;
  logic [EXP_WIDTH-1:0]   s1_res_exp_r;
  logic [SW-1:0]          s1_sig_r;

  logic                   s2_valid_r;
  logic [FW-1:0]          s2_aligned_r;
  logic [5:0]             s2_shamt_r;
  logic                   s2_small_r;
  logic                   s2_sticky_r;
  logic [EXP_WIDTH-1:0]   s2_res_exp_r;

  logic                   s2_adv_s;
  logic                   in_fire_s;
  logic [FW-1:0]          field_s;
  logic [FW-1:0]          shift_aligned_s;
  logic                   shift_sticky_s;

  assign pe_s  = $signed({3'b000, a_exp}) + $signed({3'b000, b_exp}) - BIAS_S;
  assign raw_s = pe_s - $signed({3'b000, c_exp}) + RES_TH_S;

  assign s2_adv_s  = ~s2_valid_r | out_ready;
  assign in_ready  = ~s1_valid_r | s2_adv_s;
  assign in_fire_s = in_valid & in_ready;

  // Exponent-gap decode: clamp the shift and pick the tentative result exponent.
  always_comb begin
    dec_shamt_s   = 6'd0;
    dec_small_s   = 1'b0;
    dec_res_exp_s = c_exp;
    if (raw_s <= ZERO_S) begin
      dec_shamt_s = 6'd0;
      dec_small_s = 1'b0;
    end else if (raw_s > MAX_SH_S) begin
      dec_shamt_s = 6'(MAX_SH);
      dec_small_s = 1'b1;
    end else begin
      dec_shamt_s = raw_s[5:0];
      dec_small_s = 1'b0;
    end
    if (raw_s < RES_TH_S) begin
      dec_res_exp_s = c_exp;
    end else begin
      dec_res_exp_s = pe_s[EXP_WIDTH-1:0];
    end
  end

  // Stage 1 registers: decoded shift controls plus the raw significand.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_shamt_r   <= 6'd0;
      s1_small_r   <= 1'b0;
      s1_res_exp_r <= '0;
      s1_sig_r     <= '0;
    end else begin
      if (in_fire_s) begin
        s1_valid_r   <= 1'b1;
        s1_shamt_r   <= dec_shamt_s;
        s1_small_r   <= dec_small_s;
        s1_res_exp_r <= dec_res_exp_s;
        s1_sig_r     <= c_sig;
      end else if (s2_adv_s) begin
        s1_valid_r <= 1'b0;
      end
    end
  end

  // Barrel shift; a clamped (too small) addend collapses entirely into sticky.
  always_comb begin
    field_s         = {s1_sig_r, {MAX_SH{1'b0}}} >> s1_shamt_r;
    shift_aligned_s = field_s;
    shift_sticky_s  = 1'b0;
    if (s1_small_r) begin
      shift_aligned_s = '0;
      shift_sticky_s  = |s1_sig_r;
    end else begin
      shift_aligned_s = field_s;
      shift_sticky_s  = 1'b0;
    end
  end

  // Stage 2 registers drive the outputs directly and hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r   <= 1'b0;
      s2_aligned_r <= '0;
      s2_shamt_r   <= 6'd0;
      s2_small_r   <= 1'b0;
      s2_sticky_r  <= 1'b0;
      s2_res_exp_r <= '0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_aligned_r <= shift_aligned_s;
        s2_shamt_r   <= s1_shamt_r;
        s2_small_r   <= s1_small_r;
        s2_sticky_r  <= shift_sticky_s;
        s2_res_exp_r <= s1_res_exp_r;
      end
    end
  end

  assign out_valid   = s2_valid_r;
  assign aligned     = s2_aligned_r;
  assign shamt       = s2_shamt_r;
  assign cExpIsSmall = s2_small_r;
  assign sticky      = s2_sticky_r;
  assign res_exp     = s2_res_exp_r;

endmodule

// File: tb/tb_addend_align_pipe.sv
// Randomized bench for addend_align_pipe, checked every cycle against an
// arithmetic model plus a FIFO of accepted beats.
module tb_addend_align_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_exp = 8'd0, b_exp = 8'd0, c_exp = 8'd0;
  logic [23:0] c_sig = 24'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [79:0] aligned;
  logic [5:0]  shamt;
  logic        cExpIsSmall, sticky;
  logic [7:0]  res_exp;

  addend_align_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_exp(a_exp), .b_exp(b_exp), .c_exp(c_exp), .c_sig(c_sig),
    .out_valid(out_valid), .out_ready(out_ready), .aligned(aligned),
    .shamt(shamt), .cExpIsSmall(cExpIsSmall), .sticky(sticky), .res_exp(res_exp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] al;
    logic [5:0]  sh;
    logic        sm;
    logic        st;
    logic [7:0]  re;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   live = 0;
  bit   saw_block = 0;
  int   or_mode = 0;
  int   st_a = 0, st_b = 0;

  function automatic exp_t model(int a, int b, int c, logic [23:0] sig);
    exp_t m;
    int pe, raw, sh;
    logic [79:0] f;
    pe  = a + b - 127;
    raw = pe - c + 27;
    sh  = (raw <= 0) ? 0 : ((raw > 56) ? 56 : raw);
    f   = {sig, 56'd0};
    m.sm  = (raw > 56);
    m.sh  = 6'(sh);
    m.al  = m.sm ? 80'd0 : (f >> sh);
    m.st  = m.sm && (sig != 24'd0);
    m.re  = (raw < 27) ? 8'(c) : 8'(pe);
    m.acc = 0;
    return m;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transfer monitor: pushes accepted beats and retires delivered ones.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0 && cyc >= q[0].acc + 2 && out_ready)
        void'(q.pop_front());
      if (in_valid && in_ready) begin
        exp_t m;
        m = model(int'(a_exp), int'(b_exp), int'(c_exp), c_sig);
        m.acc = cyc;
        q.push_back(m);
      end
    end
    cyc++;
  end

  // Per-cycle compare of handshake and payload against the model.
  always @(negedge clk) begin
    if (live && !rst) begin
      logic exp_ov;
      chk("in_ready", 80'(in_ready), 80'((q.size() < 2) || out_ready));
      exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
      chk("out_valid", 80'(out_valid), 80'(exp_ov));
      if (!in_ready) saw_block = 1;
      if (exp_ov && out_valid) begin
        chk("aligned", aligned, q[0].al);
        chk("shamt", 80'(shamt), 80'(q[0].sh));
        chk("cExpIsSmall", 80'(cExpIsSmall), 80'(q[0].sm));
        chk("sticky", 80'(sticky), 80'(q[0].st));
        chk("res_exp", 80'(res_exp), 80'(q[0].re));
      end
    end
  end

  task automatic advance();
    @(posedge clk);
    #1;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = !(cyc >= st_a && cyc < st_b);
    endcase
  endtask

  task automatic send(input int a, input int b, input int c, input logic [23:0] sig);
    bit took;
    a_exp = 8'(a); b_exp = 8'(b); c_exp = 8'(c); c_sig = sig;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      took = in_ready;
      advance();
      if (took) return;
    end
    checks++; failures++;
    $display("FAIL send_timeout actual=stuck required=accept");
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) advance();
  endtask

  task automatic drain();
    or_mode = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 40 && q.size() > 0; k++) advance();
    chk("drain_empty", 80'(q.size()), 80'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, 80'(out_valid), 80'd0);
    chk({tag, "_in_ready"}, 80'(in_ready), 80'd1);
    chk({tag, "_aligned"}, aligned, 80'd0);
    chk({tag, "_shamt"}, 80'(shamt), 80'd0);
    chk({tag, "_small"}, 80'(cExpIsSmall), 80'd0);
    chk({tag, "_sticky"}, 80'(sticky), 80'd0);
    chk({tag, "_res_exp"}, 80'(res_exp), 80'd0);
  endtask

  initial begin
    exp_t m;
    logic [79:0] one;
    one = 80'd1;

    // Hand-computed pins of the model itself.
    m = model(127, 127, 127, 24'h800000);
    chk("pin_nom_al", m.al, one << 52);
    chk("pin_nom_sh", 80'(m.sh), 80'd27);
    chk("pin_nom_re", 80'(m.re), 80'd127);
    m = model(127, 127, 167, 24'hABCDEF);
    chk("pin_cdom_al", m.al, {24'hABCDEF, 56'd0});
    chk("pin_cdom_sh", 80'(m.sh), 80'd0);
    chk("pin_cdom_re", 80'(m.re), 80'd167);
    m = model(127, 127, 98, 24'hFFFFFF);
    chk("pin_clamp_al", m.al, {56'd0, 24'hFFFFFF});
    chk("pin_clamp_sm", 80'(m.sm), 80'd0);
    chk("pin_clamp_re", 80'(m.re), 80'd127);
    m = model(150, 150, 1, 24'h800001);
    chk("pin_tiny_sh", 80'(m.sh), 80'd56);
    chk("pin_tiny_sm", 80'(m.sm), 80'd1);
    chk("pin_tiny_st", 80'(m.st), 80'd1);
    chk("pin_tiny_al", m.al, 80'd0);
    chk("pin_tiny_re", 80'(m.re), 80'd173);

    rst = 1'b1;
    for (int k = 0; k < 3; k++) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    live = 1;
    chk_reset_state("rst0");

    // Test-plan vectors through the pipeline, back-to-back.
    or_mode = 0;
    send(127, 127, 127, 24'h800000);
    send(127, 127, 167, 24'hABCDEF);
    send(127, 127, 98, 24'hFFFFFF);
    send(150, 150, 1, 24'h800001);
    drain();

    // Back-pressure: out_ready low for cycles 2..5 of the stream.
    saw_block = 0;
    st_a = cyc + 2; st_b = cyc + 6; or_mode = 2;
    send(10, 200, 90, 24'h812345);
    send(127, 127, 120, 24'hC00001);
    send(200, 100, 250, 24'hFEDCBA);
    send(60, 70, 3, 24'h900000);
    idle(6);
    chk("bp_in_ready_dropped", 80'(saw_block), 80'd1);
    drain();

    // Reset with both stages full; a pending beat during reset is ignored.
    st_a = cyc; st_b = cyc + 100000; or_mode = 2;
    send(130, 130, 140, 24'hA5A5A5);
    send(131, 129, 100, 24'h800F00);
    a_exp = 8'd1; b_exp = 8'd2; c_exp = 8'd3; c_sig = 24'hFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    chk("full_before_reset", 80'(q.size()), 80'd2);
    rst = 1'b1;
    advance();
    rst = 1'b0; in_valid = 1'b0; or_mode = 0; out_ready = 1'b1;
    chk_reset_state("rst_mid");
    send(127, 127, 127, 24'h800000);
    drain();

    // Randomized traffic with random back-pressure and boundary-biased gaps.
    or_mode = 1;
    for (int n = 0; n < 600; n++) begin
      int a, b, c, raw, pe;
      logic [23:0] sig;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      pe = a + b - 127;
      if ($urandom_range(0, 1) == 1) begin
        raw = $urandom_range(0, 66) - 4;
        c = pe + 27 - raw;
        if (c < 0 || c > 255) c = $urandom_range(0, 255);
      end else begin
        c = $urandom_range(0, 255);
      end
      sig = {1'b1, 23'($urandom())};
      if ($urandom_range(0, 7) == 0) sig = 24'd0;
      send(a, b, c, sig);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
